// File: rtl/digital_tube_scan_controller.sv
// rtl/digital_tube_scan_controller.sv - eight-digit seven-segment tube scan controller with double-buffered frames
//
// Purpose:
//   Time-multiplexes eight digit segment codes onto one segment bus.
//   Each digit slot is BLANK_CYCLES dark cycles followed by DWELL_CYCLES lit cycles.
//   Frames go into a shadow buffer through a valid/ready handshake.
//   The shadow buffer is copied to the displayed (active) buffer only at a scan boundary,
//   so a scan never shows a mix of two frames.
//
// Optional feature macro: SCAN_BRIGHTNESS_EN
//   When defined, adds the 3-bit input bright.
//   codeout is then lit only for the first ((bright+1)*DWELL_CYCLES)/8 cycles of each slot.
//
// Parameters:
//   DWELL_CYCLES  lit cycles per digit slot (8 or more)
//   BLANK_CYCLES  dark cycles ahead of each digit slot (1 or more)
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   frame_data   eight segment codes; digit i occupies bits [8i+7:8i]
//   frame_valid  frame_data is offered
//   frame_ready  shadow buffer is free (registered)
//   digit_en     per-digit enable mask, sampled live
//   bright       brightness level, sampled on SHOW entry (SCAN_BRIGHTNESS_EN only)
//   codeout      segment code of the current digit, active-high (registered)
//   seg          one-hot digit select, active-high (registered)
//   scan_wrap    one-cycle pulse with the last cycle of digit 7 (registered)

module digital_tube_scan_controller #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [7:0]  digit_en,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [2:0]  bright,
`endif
    output logic [7:0]  codeout,
    output logic [7:0]  seg,
    output logic        scan_wrap
);

    // The phase counter is shared by BLANK and SHOW.
    // It never exceeds the longer of the two periods minus one.
    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int PW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_next;

    logic          r_pending;
    logic          w_pending_next;
    logic [63:0]   r_shadow;
    logic [63:0]   r_active;

    logic          r_frame_ready;
    logic [7:0]    r_codeout;
    logic [7:0]    r_seg;
    logic          r_scan_wrap;

    logic          w_accept;
    logic          w_load;
    logic          w_scan_end;
    logic          w_lit;
    logic          w_code_window;
    logic [7:0]    w_cur_code;
    logic [7:0]    w_seg_next;
    logic [7:0]    w_code_next;

`ifdef SCAN_BRIGHTNESS_EN
    logic [2:0]    r_bright;
    logic [31:0]   w_bright_limit;
`endif

    // ------------------------------------------------------------------
    // Frame handshake
    // ------------------------------------------------------------------
    // frame_ready is held equal to !pending.
    // Acceptance is therefore only possible while nothing is waiting in the
    // shadow buffer, and a load never coincides with an acceptance.
    assign w_accept       = frame_valid && r_frame_ready;
    assign w_pending_next = (r_pending && !w_load) || w_accept;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_idx_next   = r_idx;
        w_load       = 1'b0;
        w_scan_end   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_load       = 1'b1;
                    w_idx_next   = 3'd0;
                    w_phase_next = '0;
                    w_state_next = ST_BLANK;
                end
            end

            ST_BLANK: begin
                if (r_phase == BLANK_LAST) begin
                    w_phase_next = '0;
                    w_state_next = ST_SHOW;
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end

            ST_SHOW: begin
                if (r_phase == DWELL_LAST) begin
                    w_phase_next = '0;
                    w_state_next = ST_BLANK;
                    // The index wraps 7 -> 0 through the natural 3-bit overflow.
                    w_idx_next   = r_idx + 1'b1;
                    if (r_idx == 3'd7) begin
                        w_scan_end = 1'b1;
                        // The scan boundary is the only point where a waiting
                        // frame may replace the displayed one.
                        w_load     = r_pending;
                    end
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // These values are registered below, so the pins show the current
    // state one cycle late. That delay is also what lines scan_wrap up
    // with the final lit cycle of digit 7.
    assign w_lit      = (r_state == ST_SHOW) && digit_en[r_idx];
    assign w_cur_code = r_active[{r_idx, 3'b000} +: 8];

`ifdef SCAN_BRIGHTNESS_EN
    assign w_bright_limit = (({29'd0, r_bright} + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
    assign w_code_window  = ({{(32-PW){1'b0}}, r_phase} < w_bright_limit);
`else
    assign w_code_window  = 1'b1;
`endif

    // A disabled digit keeps its slot timing and is simply dark,
    // so brightness across the digits stays uniform.
    assign w_seg_next  = w_lit ? (8'd1 << r_idx) : 8'd0;
    assign w_code_next = (w_lit && w_code_window) ? w_cur_code : 8'd0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase       <= '0;
            r_idx         <= 3'd0;
            r_pending     <= 1'b0;
            r_shadow      <= 64'd0;
            r_active      <= 64'd0;
            r_frame_ready <= 1'b0;
            r_codeout     <= 8'd0;
            r_seg         <= 8'd0;
            r_scan_wrap   <= 1'b0;
        end else begin
            r_phase       <= w_phase_next;
            r_idx         <= w_idx_next;
            r_pending     <= w_pending_next;
            if (w_accept) begin
                r_shadow <= frame_data;
            end
            if (w_load) begin
                r_active <= r_shadow;
            end
            r_frame_ready <= !w_pending_next;
            r_codeout     <= w_code_next;
            r_seg         <= w_seg_next;
            r_scan_wrap   <= w_scan_end;
        end
    end

`ifdef SCAN_BRIGHTNESS_EN
    // Brightness is captured as SHOW begins, so a level change never
    // takes effect part-way through a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= 3'd0;
        end else if (r_state == ST_BLANK && r_phase == BLANK_LAST) begin
            r_bright <= bright;
        end
    end
`endif

    assign frame_ready = r_frame_ready;
    assign codeout     = r_codeout;
    assign seg         = r_seg;
    assign scan_wrap   = r_scan_wrap;

endmodule

// File: tb/tb_digital_tube_scan_controller.sv
// tb/tb_digital_tube_scan_controller.sv - randomized self-checking bench for digital_tube_scan_controller

module tb_digital_tube_scan_controller;

    localparam int DW   = 8;
    localparam int BL   = 2;
    localparam int SLOT = DW + BL;
    localparam int SCAN = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  digit_en;
    logic [7:0]  codeout;
    logic [7:0]  seg;
    logic        scan_wrap;
`ifdef SCAN_BRIGHTNESS_EN
    logic [2:0]  bright;
`endif

    always #5 clk = ~clk;

    digital_tube_scan_controller #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .digit_en   (digit_en),
`ifdef SCAN_BRIGHTNESS_EN
        .bright     (bright),
`endif
        .codeout    (codeout),
        .seg        (seg),
        .scan_wrap  (scan_wrap)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the scan is a fixed 80-cycle timeline. The position p
    // within it gives the digit (p / SLOT) and the offset inside the slot.
    bit          m_run;
    int          m_t;
    logic [63:0] m_active;
    logic [63:0] m_shadow;
    bit          m_pending;
    bit          m_ready;
    int          m_bright;
    logic [7:0]  e_seg;
    logic [7:0]  e_code;
    bit          e_wrap;

    int cyc = 0;
    int last_wrap = -1;

    task automatic model_step();
        int  p;
        int  d;
        int  q;
        bit  acc;
        if (rst) begin
            m_run     = 0;
            m_t       = 0;
            m_active  = 64'd0;
            m_shadow  = 64'd0;
            m_pending = 0;
            m_ready   = 0;
            m_bright  = 0;
            e_seg     = 8'd0;
            e_code    = 8'd0;
            e_wrap    = 0;
            return;
        end
        p = m_t % SCAN;
        d = p / SLOT;
        q = p % SLOT;
        e_seg  = 8'd0;
        e_code = 8'd0;
        e_wrap = 0;
        if (m_run) begin
            if (q >= BL && digit_en[d]) begin
                e_seg  = 8'(1 << d);
                e_code = m_active[8*d +: 8];
`ifdef SCAN_BRIGHTNESS_EN
                if ((q - BL) >= ((m_bright + 1) * DW) / 8) e_code = 8'd0;
`endif
            end
            e_wrap = (p == SCAN - 1);
`ifdef SCAN_BRIGHTNESS_EN
            if (q == BL - 1) m_bright = int'(bright);
`endif
        end
        acc = frame_valid && m_ready;
        if (!m_run) begin
            if (m_pending) begin
                m_run     = 1;
                m_t       = 0;
                m_active  = m_shadow;
                m_pending = 0;
            end
        end else begin
            if (p == SCAN - 1 && m_pending) begin
                m_active  = m_shadow;
                m_pending = 0;
            end
            m_t++;
        end
        if (acc) begin
            m_shadow  = frame_data;
            m_pending = 1;
        end
        m_ready = !m_pending;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_eq("seg", seg, e_seg);
        check_eq("codeout", codeout, e_code);
        check_eq("scan_wrap", scan_wrap, e_wrap);
        check_eq("frame_ready", frame_ready, m_ready);
        if (rst) begin
            last_wrap = -1;
        end else if (scan_wrap) begin
            if (last_wrap >= 0) check_eq("wrap_period", cyc - last_wrap, SCAN);
            last_wrap = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic [63:0] data);
        bit was_ready;
        bit accepted;
        accepted    = 0;
        frame_valid = 1'b1;
        frame_data  = data;
        for (int i = 0; i < 3 * SCAN; i++) begin
            was_ready = frame_ready;
            tick();
            if (was_ready) begin
                accepted = 1;
                break;
            end
        end
        frame_valid = 1'b0;
        check_eq("send_accept", accepted, 1);
        check_eq("ready_low_after_accept", frame_ready, 0);
    endtask

    initial begin
        int lit;
        bit found;

        rst         = 1'b1;
        frame_valid = 1'b1;
        frame_data  = {$urandom, $urandom};
        digit_en    = 8'hFF;
`ifdef SCAN_BRIGHTNESS_EN
        bright      = 3'd1;
`endif
        run(3);

        // Basic scan of a counting frame
        rst         = 1'b0;
        frame_valid = 1'b0;
        send_frame(64'h0706050403020100);
        run(2 * SCAN + 5);

        // A frame arrives mid-scan and must wait for the boundary
        run(35);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF);
        run(2 * SCAN);

        // Upper digits disabled
        send_frame(64'h1122334455667788);
        digit_en = 8'h0F;
        run(2 * SCAN);
        digit_en = 8'hFF;

        // Reset during the digit 3 SHOW slot
        found = 0;
        for (int i = 0; i < 2 * SCAN; i++) begin
            if (m_run && ((m_t % SCAN) / SLOT) == 3 && (m_t % SLOT) >= BL + 2) begin
                found = 1;
                break;
            end
            tick();
        end
        check_eq("reached_digit3", found, 1);
        rst         = 1'b1;
        frame_valid = 1'b1;
        tick();
        rst         = 1'b0;
        frame_valid = 1'b0;
        lit = 0;
        for (int i = 0; i < SCAN + 10; i++) begin
            tick();
            if (seg != 8'd0 || codeout != 8'd0) lit++;
        end
        check_eq("dark_after_reset", lit, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            frame_valid = ($urandom_range(0, 19) == 0);
            frame_data  = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) digit_en = 8'($urandom);
`ifdef SCAN_BRIGHTNESS_EN
            if ($urandom_range(0, 49) == 0) bright = 3'($urandom);
`endif
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst         = 1'b0;
        frame_valid = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
